// File: rtl/regfile_chk_pkg.sv
// Shared types for the register-file checker input stage: display-select codes,
// load-target codes and write FSM states.
package regfile_chk_pkg;

  typedef enum logic [2:0] {
    SEL_RD1 = 3'd0,
    SEL_RD2 = 3'd1,
    SEL_WD3 = 3'd2,
    SEL_A1  = 3'd3,
    SEL_A2  = 3'd4,
    SEL_A3  = 3'd5
  } sel_e;

  localparam sel_e SEL_LAST = SEL_A3;

  typedef enum logic [1:0] {
    TGT_A1  = 2'b00,
    TGT_A2  = 2'b01,
    TGT_A3  = 2'b10,
    TGT_WD3 = 2'b11
  } tgt_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    HOLD  = 2'd2
  } wr_state_e;

  function automatic sel_e sel_next(input sel_e s);
    return (s == SEL_LAST) ? SEL_RD1 : sel_e'(s + 3'd1);
  endfunction

endpackage

// File: rtl/regfile_chk_input_ctrl_if.sv
// Board-side bundle of the input stage: switches/keys in, regfile and display controls out.
interface regfile_chk_input_ctrl_if;
  logic [17:0] sw;
  logic [2:0]  key;
  logic [4:0]  a1;
  logic [4:0]  a2;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic        we3;
  logic [2:0]  selm;
  logic [7:0]  wr_cnt;

  modport master (
    input  sw, key,
    output a1, a2, a3, wd3, we3, selm, wr_cnt
  );

  modport slave (
    output sw, key,
    input  a1, a2, a3, wd3, we3, selm, wr_cnt
  );
endinterface

// File: rtl/key_debounce.sv
// Active-low pushbutton synchroniser and debouncer with a single-cycle press pulse.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic pressed,
  output logic press_pulse
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q;
  logic            raw_pressed;
  logic            pressed_q, pressed_d;
  logic            pulse_q, pulse_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  assign raw_pressed = ~sync_q[1];

  // Counter runs only while the synchronised input disagrees with the debounced state.
  always_comb begin
    pressed_d = pressed_q;
    pulse_d   = 1'b0;
    cnt_d     = '0;
    if (raw_pressed != pressed_q) begin
      if (cnt_q == CntMax) begin
        pressed_d = raw_pressed;
        pulse_d   = raw_pressed;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= 2'b11;
      pressed_q <= 1'b0;
      pulse_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync_q    <= {sync_q[0], key_n};
      pressed_q <= pressed_d;
      pulse_q   <= pulse_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pressed     = pressed_q;
  assign press_pulse = pulse_q;

endmodule

// File: rtl/regfile_chk_input_ctrl.sv
// Input stage of the regfile checker: debounced keys load operands, issue writes, step selm.
// Optional macro AUTO_SCROLL_EN: selm auto-advances every SCROLL_CYCLES, KEY2 pauses/resumes.
module regfile_chk_input_ctrl
  import regfile_chk_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned SCROLL_CYCLES   = 50000000
) (
  input logic                      clk,
  input logic                      rst_n,
  regfile_chk_input_ctrl_if.master bus
);

  logic [2:0]  key_pressed;
  logic [2:0]  key_pulse;

  logic [4:0]  a1_q, a1_d, a2_q, a2_d, a3_q, a3_d;
  logic [31:0] wd3_q, wd3_d;
  logic [7:0]  wr_cnt_q, wr_cnt_d;
  sel_e        selm_q, selm_d;
  wr_state_e   state_q, state_d;
  logic        we3;

  // Index 0 = KEY1 (load), 1 = KEY2 (display), 2 = KEY3 (write).
  for (genvar i = 0; i < 3; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_n      (bus.key[i]),
      .pressed    (key_pressed[i]),
      .press_pulse(key_pulse[i])
    );
  end

  always_comb begin
    a1_d  = a1_q;
    a2_d  = a2_q;
    a3_d  = a3_q;
    wd3_d = wd3_q;
    if (key_pulse[0]) begin
      unique case (tgt_e'(bus.sw[17:16]))
        TGT_A1:  a1_d  = bus.sw[4:0];
        TGT_A2:  a2_d  = bus.sw[4:0];
        TGT_A3:  a3_d  = bus.sw[4:0];
        TGT_WD3: wd3_d = {wd3_q[15:0], bus.sw[15:0]};
      endcase
    end
  end

  // HOLD waits for KEY3 release so a held key never produces a second write.
  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    we3      = 1'b0;
    unique case (state_q)
      IDLE: if (key_pulse[2]) state_d = WRITE;
      WRITE: begin
        we3      = 1'b1;
        wr_cnt_d = wr_cnt_q + 8'd1;
        state_d  = HOLD;
      end
      HOLD: if (!key_pressed[2]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef AUTO_SCROLL_EN
  localparam int unsigned ScrollW = (SCROLL_CYCLES > 1) ? $clog2(SCROLL_CYCLES) : 1;
  localparam logic [ScrollW-1:0] ScrollMax = ScrollW'(SCROLL_CYCLES - 1);

  logic [ScrollW-1:0] scroll_q, scroll_d;
  logic               paused_q, paused_d;

  always_comb begin
    paused_d = paused_q ^ key_pulse[1];
    scroll_d = scroll_q;
    selm_d   = selm_q;
    if (!paused_q) begin
      if (scroll_q == ScrollMax) begin
        scroll_d = '0;
        selm_d   = sel_next(selm_q);
      end else begin
        scroll_d = scroll_q + ScrollW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scroll_q <= '0;
      paused_q <= 1'b0;
    end else begin
      scroll_q <= scroll_d;
      paused_q <= paused_d;
    end
  end
`else
  always_comb begin
    selm_d = selm_q;
    if (key_pulse[1]) selm_d = sel_next(selm_q);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1_q     <= '0;
      a2_q     <= '0;
      a3_q     <= '0;
      wd3_q    <= '0;
      wr_cnt_q <= '0;
      selm_q   <= SEL_RD1;
      state_q  <= IDLE;
    end else begin
      a1_q     <= a1_d;
      a2_q     <= a2_d;
      a3_q     <= a3_d;
      wd3_q    <= wd3_d;
      wr_cnt_q <= wr_cnt_d;
      selm_q   <= selm_d;
      state_q  <= state_d;
    end
  end

  assign bus.a1     = a1_q;
  assign bus.a2     = a2_q;
  assign bus.a3     = a3_q;
  assign bus.wd3    = wd3_q;
  assign bus.we3    = we3;
  assign bus.selm   = selm_q;
  assign bus.wr_cnt = wr_cnt_q;

endmodule

// File: tb/tb_regfile_chk_input_ctrl.sv
// Scoreboard bench for regfile_chk_input_ctrl; covers AUTO_SCROLL_EN when that macro is defined.
module tb_regfile_chk_input_ctrl;
  import regfile_chk_pkg::*;

  localparam int unsigned DEB = 4;
  localparam int unsigned SCR = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  regfile_chk_input_ctrl_if bus ();

  regfile_chk_input_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .SCROLL_CYCLES  (SCR)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic [7:0]  cnt;
  } wr_t;

  wr_t        wr_q[$];
  logic [2:0] sel_q[$];
  int tests = 0;
  int fails = 0;
  int we_seen = 0;
  int key1_pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int idx, input int hold);
    bus.key[idx] = 1'b0;
    cyc(hold);
    bus.key[idx] = 1'b1;
    cyc(12);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write or a new selm value.
  initial begin
    logic [2:0] prev_sel;
    wr_t        e;
    prev_sel = 3'd0;
    forever begin
      @(negedge clk);
      if (dut.g_key[0].u_key.press_pulse === 1'b1) key1_pulses++;
      if (rst_n && bus.we3 === 1'b1) begin
        we_seen++;
        if (wr_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got we3=1 a3=%0h expected no write", bus.a3);
        end else begin
          e = wr_q.pop_front();
          check("wr_a1", bus.a1, e.a1);
          check("wr_a2", bus.a2, e.a2);
          check("wr_a3", bus.a3, e.a3);
          check("wr_wd3", bus.wd3, e.wd3);
          check("wr_cnt_during_write", bus.wr_cnt, e.cnt);
        end
      end
`ifndef AUTO_SCROLL_EN
      if (bus.selm !== prev_sel) begin
        if (rst_n) begin
          if (sel_q.size() == 0) check("unexpected_selm", bus.selm, prev_sel);
          else check("selm_step", bus.selm, sel_q.pop_front());
        end
        prev_sel = bus.selm;
      end
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int         gl[6];
    logic       found;
    logic [2:0] s0;
    int         gap;
    gl = '{2, 1, 3, 2, 1, 3};
    bus.key = 3'b111;
    bus.sw  = 18'h0;
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
    check("rst_a1", bus.a1, 0);
    check("rst_a2", bus.a2, 0);
    check("rst_a3", bus.a3, 0);
    check("rst_wd3", bus.wd3, 0);
    check("rst_selm", bus.selm, 0);
    check("rst_wr_cnt", bus.wr_cnt, 0);
    check("rst_we3", bus.we3, 0);

    // KEY1 with three short glitches, then a clean press.
    bus.sw = 18'h0_0011;
    for (int i = 0; i < 6; i++) begin
      bus.key[0] = (i % 2 == 0) ? 1'b0 : 1'b1;
      cyc(gl[i]);
    end
    bus.key[0] = 1'b0;
    cyc(6);
    check("a1_not_yet", bus.a1, 0);
    cyc(1);
    check("a1_load_latency", bus.a1, 5'h11);
    bus.key[0] = 1'b1;
    cyc(12);
    check("key1_single_pulse", key1_pulses, 1);

    // Build wd3 upper half first, then set a3 and write with KEY3 held.
    bus.sw = {2'b11, 16'hDEAD};
    press(0, 8);
    bus.sw = {2'b11, 16'hBEEF};
    press(0, 8);
    check("wd3_shift_in", bus.wd3, 32'hDEADBEEF);
    bus.sw = {2'b10, 16'h0007};
    press(0, 8);
    check("a3_load", bus.a3, 5'h07);
    wr_q.push_back('{a1: 5'h11, a2: 5'h00, a3: 5'h07, wd3: 32'hDEADBEEF, cnt: 8'd0});
    press(2, 20);
    check("wr_cnt_after_first", bus.wr_cnt, 1);
    check("we3_once_while_held", we_seen, 1);

    // KEY1 and KEY3 aligned: the write must present the freshly loaded a3.
    bus.sw = {2'b10, 16'h001F};
    wr_q.push_back('{a1: 5'h11, a2: 5'h00, a3: 5'h1F, wd3: 32'hDEADBEEF, cnt: 8'd1});
    bus.key[0] = 1'b0;
    bus.key[2] = 1'b0;
    cyc(12);
    bus.key = 3'b111;
    cyc(12);
    check("wr_cnt_after_aligned", bus.wr_cnt, 2);
    check("we3_count_aligned", we_seen, 2);

`ifndef AUTO_SCROLL_EN
    for (int i = 0; i < 7; i++) begin
      sel_q.push_back(3'((i + 1) % 6));
      press(1, 8);
    end
    check("selm_queue_drained", sel_q.size(), 0);
    check("selm_final", bus.selm, 1);
`else
    found = 1'b0;
    s0 = bus.selm;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bus.selm !== s0) found = 1'b1;
    end
    check("scroll_started", found, 1);
    for (int k = 0; k < 7; k++) begin
      s0 = bus.selm;
      gap = 0;
      do begin
        @(negedge clk);
        gap++;
      end while (bus.selm === s0 && gap < 40);
      check("scroll_period", gap, SCR);
      check("scroll_value", bus.selm, (s0 == 3'd5) ? 3'd0 : s0 + 3'd1);
    end
    cyc(1);
    press(1, 8);
    s0 = bus.selm;
    cyc(40);
    check("scroll_paused", bus.selm, s0);
    press(1, 8);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (bus.selm !== s0) found = 1'b1;
      else @(negedge clk);
    end
    check("scroll_resumed", found, 1);
    check("scroll_resume_value", bus.selm, (s0 == 3'd5) ? 3'd0 : s0 + 3'd1);
    cyc(1);
`endif

    // Reset asserted in the middle of the WRITE cycle.
    wr_q.push_back('{a1: 5'h11, a2: 5'h00, a3: 5'h1F, wd3: 32'hDEADBEEF, cnt: 8'd2});
    bus.key[2] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (bus.we3 === 1'b1) found = 1'b1;
    end
    check("we3_reached", found, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_we3_drop", bus.we3, 0);
    check("async_wr_cnt", bus.wr_cnt, 0);
    check("async_fsm_idle", dut.state_q, IDLE);
    check("async_a3", bus.a3, 0);
    check("async_wd3", bus.wd3, 0);
    check("async_selm", bus.selm, 0);
    bus.key[2] = 1'b1;
    cyc(4);
    rst_n = 1'b1;
    cyc(12);
    check("no_write_after_reset", we_seen, 3);
    check("wr_queue_drained", wr_q.size(), 0);
    check("wr_cnt_stays_zero", bus.wr_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
